// File: rtl/bram_rd_arbiter_n.sv
// rtl/bram_rd_arbiter_n.sv - N-port arbiter for one shared BRAM read port with per-port read-valid tagging
//
// Purpose: grants one of NUM_REQ readers per cycle onto a single BRAM read
// port and returns a one-hot req_rvalid RD_LATENCY cycles after each grant.
// Optional feature macro: BRAM_ARB_RR_EN selects round-robin arbitration with
// a MAX_BURST hold. When it is undefined, the lowest index wins and MAX_BURST
// is ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       per-requester read request
//   req_addr        flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_gnt         one-hot grant, combinational in the request cycle
//   req_rdata       bram_data broadcast to all requesters
//   req_rvalid      one-hot owner of req_rdata this cycle
//   bram_addr       address to BRAM (0 when idle)
//   bram_re         read enable to BRAM
//   bram_data       BRAM read data, RD_LATENCY cycles after bram_re
//   busy            any read still in flight in the tag pipe
module bram_rd_arbiter_n #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            req_rvalid,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_re,
  input  logic [DATA_WIDTH-1:0]         bram_data,
  output logic                          busy
);

  // Parameter range checks at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be 2..8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $error("RD_LATENCY must be 1..3");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end

  logic [NUM_REQ-1:0] gnt_c;

`ifdef BRAM_ARB_RR_EN
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] burst_cnt;

  logic             hold_keep;
  logic [IDX_W-1:0] scan_start;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] pick;
  logic             found;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  always_comb begin
    hold_keep  = (state == HOLD) && req_valid[owner] && (burst_cnt < CNT_W'(MAX_BURST));
    // Ending a burst searches from owner+1 in the same cycle, so there is no bubble.
    scan_start = (state == HOLD) ? wrap_inc(owner) : rr_ptr;
    scan_idx   = '0;
    pick       = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(scan_start) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
    gnt_c = '0;
    if (hold_keep) gnt_c[owner] = 1'b1;
    else if (found) gnt_c[pick] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (hold_keep) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else begin
      if (state == HOLD) rr_ptr <= wrap_inc(owner);
      if (found) begin
        owner     <= pick;
        burst_cnt <= CNT_W'(1);
        if (MAX_BURST > 1) begin
          state <= HOLD;
        end else begin
          state  <= IDLE;
          rr_ptr <= wrap_inc(pick);
        end
      end else begin
        state <= IDLE;
      end
    end
  end
`else
  // Static priority: scanning downward lets the lowest valid index overwrite.
  always_comb begin
    gnt_c = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_c    = '0;
        gnt_c[i] = 1'b1;
      end
    end
  end
`endif

  // Grant is forced low during reset so the BRAM sees no read while rst is high.
  assign req_gnt   = rst ? '0 : gnt_c;
  assign bram_re   = |req_gnt;
  assign req_rdata = bram_data;

  always_comb begin
    bram_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_gnt[i]) bram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Tag pipe: one one-hot grant vector per BRAM latency stage.
  logic [NUM_REQ-1:0] tag_pipe [RD_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= req_gnt;
      for (int s = 1; s < RD_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign req_rvalid = tag_pipe[RD_LATENCY-1];

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < RD_LATENCY; s++) busy = busy | (|tag_pipe[s]);
  end

endmodule

// File: doc/bram_rd_arbiter_n.md
# bram_rd_arbiter_n

Parametrised N-port arbiter for one shared BRAM read port, replacing the fixed three-requester static mux in the unoptimised flow. It sits between the frame/pyramid BRAM and its readers (pyramid builder, frame warper, pixel sequencer, future readers). It grants one requester per cycle and tracks BRAM read latency so that each requester gets a per-port data-valid strobe. Concurrent requesters are now legal, so BUILD, WARP and SOLVE stages can overlap.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, 2..8.
- ADDR_WIDTH, 18: BRAM address width.
- DATA_WIDTH, 8: BRAM data width.
- RD_LATENCY, 1: BRAM read latency in cycles, 1..3.
- MAX_BURST, 4: maximum consecutive grants to one owner. Used only with BRAM_ARB_RR_EN.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, NUM_REQ: per-requester read request.
- req_addr, in, NUM_REQ*ADDR_WIDTH: flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_gnt, out, NUM_REQ: one-hot grant, combinational in the same cycle.
- req_rdata, out, DATA_WIDTH: bram_data broadcast to all requesters.
- req_rvalid, out, NUM_REQ: one-hot; req_rdata belongs to requester i.
- bram_addr, out, ADDR_WIDTH: address to BRAM.
- bram_re, out, 1: read enable to BRAM.
- bram_data, in, DATA_WIDTH: BRAM read data, valid RD_LATENCY cycles after bram_re.
- busy, out, 1: high while any read is in flight in the tag pipe.

## Operation
- **Handshake:** a read is accepted in a cycle where req_valid[i] && req_gnt[i]. A requester holds req_valid and req_addr stable until it is granted.
- **Grant:** req_gnt is one-hot or zero. req_gnt != 0 exactly when req_valid != 0.
- **BRAM drive:** bram_re = |req_gnt. bram_addr = address of the granted requester, else 0.
- **Tag pipe:** RD_LATENCY stages, each holding NUM_REQ bits, loaded with req_gnt every cycle. req_rvalid = last stage. req_rdata = bram_data, no register.
- **busy:** OR of all tag pipe stages.
- **Default arbitration (macro off):** static priority, lowest index wins. No internal state other than the tag pipe.
- **Round-robin arbitration (macro on):** FSM with states IDLE and HOLD. Registers: owner (clog2 NUM_REQ bits), burst_cnt (clog2(MAX_BURST+1) bits), rr_ptr.
  - IDLE: grant the first valid requester searching from rr_ptr upward, wrapping modulo NUM_REQ. On a grant: owner <= i, burst_cnt <= 1. If MAX_BURST > 1, go to HOLD; otherwise rr_ptr <= i+1 (mod NUM_REQ) and stay in IDLE.
  - HOLD, req_valid[owner] high and burst_cnt < MAX_BURST: grant owner, burst_cnt++.
  - HOLD, req_valid[owner] low or burst_cnt == MAX_BURST: set rr_ptr <= owner+1 (mod NUM_REQ). In the same cycle, arbitrate as IDLE from owner+1, so no bubble.
  - Ending a burst to take a grant applies the IDLE grant rules, so a new burst starts at once.
  - No requests: return to IDLE. rr_ptr is held.

## Timing
- Request to grant: 0 cycles, combinational.
- Grant to req_rvalid: exactly RD_LATENCY cycles. Throughput is one read per cycle.
- Reset values: req_gnt = 0, req_rvalid = 0, bram_re = 0, bram_addr = 0, busy = 0, state = IDLE, rr_ptr = 0, owner = 0, burst_cnt = 0.
- Reset mid-read: all in-flight tags are dropped and no req_rvalid follows. Requesters reissue.
- Requester drops req_valid while granted: no read for it that cycle. The pending tag for the earlier accepted read is unaffected.
- rr_ptr wraps from NUM_REQ-1 to 0.
- At most one req_rvalid bit is high per cycle.

## Configuration
- BRAM_ARB_RR_EN defined: round-robin with MAX_BURST burst hold, as above. Any continuously requesting port is granted within (NUM_REQ-1)*MAX_BURST cycles.
- BRAM_ARB_RR_EN undefined: static lowest-index priority, drop-in equivalent to the old three-port mux. The FSM registers are not generated and MAX_BURST is ignored.

## Test plan
Common setup: NUM_REQ=3, RD_LATENCY=2, MAX_BURST=4.
- Single requester: req1 at address 0x00100 for 1 cycle -> gnt=3'b010 and bram_addr=0x00100 in cycle 0; rvalid=3'b010 in cycle 2 carrying mem[0x00100]; busy high in cycles 1-2.
- Static mode (macro off), all three requesting continuously -> gnt=001 every cycle; req1 and req2 never granted.
- RR mode, all three continuously requesting from reset -> grants 0,0,0,0,1,1,1,1,2,2,2,2,0...; rvalid follows the same sequence delayed by 2 cycles.
- RR mode, early release: req0 drops after 2 grants while req2 is waiting -> req2 granted in the next cycle with no idle cycle; rr_ptr = 1 after the release.
- Reset mid-read: rst asserted 1 cycle after a grant to req2 -> rvalid stays 000 through and after reset; outputs return to reset values immediately.
- Back-to-back addresses: req0 at 0x0..0x7 and req1 at 0x100..0x107 -> every returned datum matches the BRAM model and is tagged to the correct port; no req_rvalid cycle is lost or duplicated.
